fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/pc_reg.sv | 29 ++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32 front-end definitions.
//   * base opcode constants (instr[6:0]) consumed by decode
//   * NOP_INSTR (addi x0, x0, 0), used as the bubble in IF/ID
//   * fetch_state_t, the fetch FSM encoding
// Macro FETCH_MISALIGN_TRAP_EN adds the HALT state for misaligned redirects.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] J      = 7'b1101111;
  localparam logic [6:0] JR     = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    KILL
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT
`endif
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// pc_reg -- fetch program counter.
//   clk, rst_n : clock, asynchronous active-low reset (PC <= RESET_PC)
//   load_en    : load load_pc (redirect); has priority over inc_en
//   load_pc    : redirect target
//   inc_en     : advance PC by 4, wrapping modulo 2^32
//   pc         : current fetch address
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [31:0] load_pc,
  input  logic        inc_en,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_pc;
    end else if (inc_en) begin
      // 32-bit add drops the carry, so 32'hFFFF_FFFC wraps to 0
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- RV32 instruction fetch with IF/ID register and one-entry skid.
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req/imem_addr    : request valid / address (= PC)
//   imem_gnt              : request accepted this cycle
//   imem_rvalid/imem_rdata: response valid / instruction word
//   id_stall              : decode cannot accept, hold IF/ID
//   redirect_valid/_pc    : branch/jump redirect and its target
//   if_id_valid/_pc/_instr: IF/ID register contents
//   fetch_misaligned      : sticky misaligned-redirect flag
// Macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises
// fetch_misaligned; without it the target's low two bits are forced to zero.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        fetch_misaligned
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pend_pc;
  logic [31:0]  redir_tgt;
  logic         skid_valid;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;
  logic         gnt_take;
  logic         rsp_take;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic redir_bad;
  logic misalign_q;

  assign redir_tgt = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= redir_bad;
    end
  end

  assign fetch_misaligned = misalign_q;
`else
  logic unused_lsbs;

  assign redir_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_lsbs      = ^redirect_pc[1:0];
  assign fetch_misaligned = 1'b0;
`endif

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (redirect_valid),
    .load_pc (redir_tgt),
    .inc_en  (gnt_take),
    .pc      (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    gnt_take  = 1'b0;
    rsp_take  = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        // a full skid means IF/ID is stalled with a spare instruction queued
        imem_req = !skid_valid;
        if (imem_req && imem_gnt) begin
          gnt_take  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          rsp_take  = 1'b1;
          state_nxt = REQ;
        end
      end
      KILL: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = IDLE;
    endcase

    if (redirect_valid) begin
      rsp_take = 1'b0;
      // KILL only while a response is still owed; a response landing in the
      // redirect cycle itself closes the transaction, so go straight to REQ.
      if (gnt_take || (((state == WAIT) || (state == KILL)) && !imem_rvalid)) begin
        state_nxt = KILL;
      end else begin
        state_nxt = REQ;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redir_bad) begin
        state_nxt = HALT;
      end
`endif
    end
  end

  // IF/ID register and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_pc     <= 32'h0000_0000;
      skid_valid  <= 1'b0;
      skid_pc     <= 32'h0000_0000;
      skid_instr  <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (gnt_take) begin
        pend_pc <= pc;
      end
      if (redirect_valid) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
        skid_valid  <= 1'b0;
      end else if (rsp_take) begin
        // skid is always empty here: requests stop while it is full
        if (!if_id_valid || !id_stall) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= pend_pc;
          if_id_instr <= imem_rdata;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= pend_pc;
          skid_instr <= imem_rdata;
        end
      end else if (!id_stall) begin
        if (skid_valid) begin
          if_id_valid <= 1'b1;
          if_id_pc    <= skid_pc;
          if_id_instr <= skid_instr;
          skid_valid  <= 1'b0;
        end else begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed scenarios plus randomized traffic for fetch_stage,
// checked every cycle against a queue-based model of the fetch front end.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        fetch_misaligned;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .id_stall         (id_stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_instr      (if_id_instr),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Reference model: instructions delivered to decode form a queue of at most
  // two entries (front = IF/ID); one memory transaction may be in flight,
  // possibly marked stale by a redirect.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  bit          m_started, m_out, m_stale, m_halt, m_flag;
  logic [31:0] m_pc, m_pend;

  // memory-side responder
  bit          rsp_pend = 1'b0;
  int          rsp_cnt  = 0;
  logic [31:0] rsp_addr = 32'h0;

  function automatic bit exp_req();
    return m_started && !m_out && !m_halt && (q.size() < 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_halt = 1'b0; m_flag = 1'b0;
    m_pc = RST_PC; m_pend = 32'h0;
  endtask

  task automatic model_step();
    bit          gnt_ok, arrive;
    logic [31:0] tgt;
    ent_t        e;
    gnt_ok = exp_req() && imem_gnt;
    arrive = m_out && imem_rvalid;
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt = redirect_pc;
`else
    tgt = redirect_pc & 32'hFFFF_FFFC;
`endif
    if (arrive) m_out = 1'b0;
    if (!redirect_valid) begin
      if (!id_stall && q.size() > 0) void'(q.pop_front());
      if (arrive && !m_stale) begin
        e.pc = m_pend; e.instr = mem_word(m_pend);
        q.push_back(e);
      end
      if (arrive) m_stale = 1'b0;
      if (gnt_ok) begin
        m_out = 1'b1; m_stale = 1'b0; m_pend = m_pc; m_pc = m_pc + 32'd4;
      end
    end else begin
      q.delete();
      if (m_out) m_stale = 1'b1;
      if (gnt_ok) begin m_out = 1'b1; m_stale = 1'b1; end
      m_pc = tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_halt = 1'b1; m_flag = 1'b1; m_out = 1'b0;
      end else begin
        m_halt = 1'b0; m_flag = 1'b0;
      end
`endif
    end
    m_started = 1'b1;
  endtask

  task automatic compare();
    bit r;
    r = exp_req();
    check_val("imem_req", 32'(imem_req), 32'(r));
    if (r) check_val("imem_addr", imem_addr, m_pc);
    check_val("if_id_valid", 32'(if_id_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check_val("if_id_pc", if_id_pc, q[0].pc);
      check_val("if_id_instr", if_id_instr, q[0].instr);
    end else begin
      check_val("if_id_nop", if_id_instr, NOP_INSTR);
    end
    check_val("fetch_misaligned", 32'(fetch_misaligned), 32'(m_flag));
  endtask

  // One clock: drive inputs just after a rising edge, advance the model,
  // then compare once the next edge has settled.
  task automatic step(input bit stall, input bit rv, input logic [31:0] rpc,
                      input bit g, input int k, input bit stray);
    id_stall = stall; redirect_valid = rv; redirect_pc = rpc;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(rsp_addr); rsp_pend = 1'b0;
      end else begin
        rsp_cnt--;
      end
    end else if (stray) begin
      imem_rvalid = 1'b1;
    end
    imem_gnt = g;
    if (rst_n && imem_req && g) begin
      rsp_pend = 1'b1; rsp_addr = imem_addr; rsp_cnt = k - 1;
    end
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk); #1;
    compare();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    rsp_pend = 1'b0;
    #1;
    model_reset();
    compare();
    check_val("rst_if_id_pc", if_id_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);  // rvalid pulse while in reset
    check_val("rst_hold_valid", 32'(if_id_valid), 32'h0);
    check_val("rst_hold_instr", if_id_instr, NOP_INSTR);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // back-to-back fetch, single-cycle memory
    check_val("boot_req_idle", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);  // stray rvalid in IDLE ignored
    check_val("boot_addr0", imem_addr, 32'h0);
    check_val("boot_req", 32'(imem_req), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("boot_wait_req", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("boot_valid", 32'(if_id_valid), 32'h1);
    check_val("boot_pc0", if_id_pc, 32'h0);
    check_val("boot_addr4", imem_addr, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("boot_addr8", imem_addr, 32'h8);

    // stall with a filled skid
    for (int i = 0; i < 40 && !(q.size() > 0 && q[0].pc == 32'h10); i++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("stall_reach", if_id_pc, 32'h10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("stall_hold_instr", if_id_instr, 32'h0050_0093);
    check_val("stall_hold_pc", if_id_pc, 32'h10);
    check_val("stall_skid_noreq", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    check_val("stall_release_pc", if_id_pc, 32'h14);
    check_val("stall_release_req", 32'(imem_req), 32'h1);

    // redirect during WAIT kills the in-flight response
    apply_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1, 1'b0);
    check_val("kill_flush", 32'(if_id_valid), 32'h0);
    check_val("kill_noreq", 32'(imem_req), 32'h0);
    for (int i = 0; i < 10 && !imem_req; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("kill_exit_req", 32'(imem_req), 32'h1);
    check_val("kill_new_addr", imem_addr, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    check_val("kill_new_pc", if_id_pc, 32'h100);
    check_val("kill_new_instr", if_id_instr, mem_word(32'h100));

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1, 1'b0);
    check_val("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    check_val("wrap_addr", imem_addr, 32'h0);
    check_val("wrap_pc", if_id_pc, 32'hFFFF_FFFC);

    // misaligned redirect
    apply_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    step(1'b0, 1'b1, 32'h102, 1'b0, 1, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_val("mis_flag", 32'(fetch_misaligned), 32'h1);
    check_val("mis_noreq", 32'(imem_req), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    check_val("mis_sticky", 32'(fetch_misaligned), 32'h1);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1, 1'b0);
    check_val("mis_clear", 32'(fetch_misaligned), 32'h0);
    check_val("mis_addr", imem_addr, 32'h200);
`else
    check_val("mis_flag_tied", 32'(fetch_misaligned), 32'h0);
    check_val("mis_forced_addr", imem_addr, 32'h100);
`endif

    // reset in the middle of a transaction
    idle(1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 4, 1'b0);
    apply_reset();
    check_val("mid_rst_valid", 32'(if_id_valid), 32'h0);
    check_val("mid_rst_flag", 32'(fetch_misaligned), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    check_val("mid_rst_first", imem_addr, RST_PC);
    check_val("mid_rst_req", 32'(imem_req), 32'h1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, t,
           $urandom_range(0, 9) < 6, int'($urandom_range(1, 4)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
